dmem_arbiter: RTL and testbench

- Arbitrates the single-port synchronous data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Sits between the MEM-stage pipeline register outputs and the data_mem instance.
- The CPU normally owns the memory. DBG gets a slot when the CPU is idle, or after a bounded starvation window. DBG may lock the memory for bursts (program/data load).
- When the CPU loses arbitration it gets a stall signal, which freezes the EXE/MEM pipeline register.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants for the data-memory arbiter: FSM state
//                encoding and default memory geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Arbiter FSM state encoding
    localparam logic [0:0] ST_CPU      = 1'b0;
    localparam logic [0:0] ST_DBG_LOCK = 1'b1;

    // Default data-memory geometry (word address, word width)
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of the single-port synchronous
//                data memory. The CPU MEM stage normally owns the memory; the
//                debug/loader port gets idle slots, is forced in after
//                MAX_CPU_RUN consecutive CPU grants while it waits, and can
//                lock the memory for bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU (MEM stage) port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // Debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    // Data memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // A zero-length run counter is not legal; keep at least one bit so the
    // MAX_CPU_RUN=0 configuration (DBG always wins) still elaborates.
    localparam int CNT_W = (MAX_CPU_RUN > 0) ? $clog2(MAX_CPU_RUN + 1) : 1;
    localparam logic [CNT_W-1:0] c_run_max = CNT_W'(MAX_CPU_RUN);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_dbg_rvalid;

    logic             w_run_sat;
    logic             w_dbg_gnt;
    logic             w_cpu_gnt;

    // Same-cycle grant decision: lock gives DBG everything, otherwise the CPU
    // wins unless it is idle or has used up its run budget.
    always_comb begin
        w_run_sat = (r_run_cnt == c_run_max);
        if (r_state == ST_DBG_LOCK) begin
            w_dbg_gnt = dbg_req;
        end else begin
            w_dbg_gnt = dbg_req & (~cpu_req | w_run_sat);
        end
        w_cpu_gnt = cpu_req & ~w_dbg_gnt & (r_state == ST_CPU);
    end

    // Memory port mux; with no grant the CPU address is presented as a
    // harmless read so mem_we never fires for an ungranted requester.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        if (w_dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
        end else if (w_cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    // Lock FSM, starvation counter and DBG read-valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_CPU;
            r_run_cnt    <= '0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_CPU: begin
                    if (w_dbg_gnt && dbg_lock) begin
                        r_state <= ST_DBG_LOCK;
                    end
                end
                ST_DBG_LOCK: begin
                    // The final cycle of a burst is still granted; ownership
                    // returns to the CPU on the following cycle.
                    if (!dbg_req || !dbg_lock) begin
                        r_state <= ST_CPU;
                    end
                end
                default: r_state <= ST_CPU;
            endcase

            if (w_dbg_gnt || !dbg_req) begin
                r_run_cnt <= '0;
            end else if (w_cpu_gnt && !w_run_sat) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end

            // Memory read data appears one cycle after the address edge.
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
        end
    end

    assign dbg_gnt    = w_dbg_gnt;
    assign cpu_stall  = cpu_req & ~w_cpu_gnt;
    assign dbg_rvalid = r_dbg_rvalid;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a
//                behavioural synchronous data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Outputs of a second instance configured with MAX_CPU_RUN=0
    logic [DATA_W-1:0] z_cpu_rdata;
    logic              z_cpu_stall;
    logic              z_dbg_gnt;
    logic [DATA_W-1:0] z_dbg_rdata;
    logic              z_dbg_rvalid;
    logic [ADDR_W-1:0] z_mem_addr;
    logic [DATA_W-1:0] z_mem_wdata;
    logic              z_mem_we;

    int checks;
    int errors;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_RUN(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(z_dbg_gnt), .dbg_rdata(z_dbg_rdata), .dbg_rvalid(z_dbg_rvalid),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_we(z_mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_lock  = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;

        // ---- Reset state
        #2;
        check("rst_state", 32'(dut.r_state), 32'(ST_CPU));
        check("rst_run_cnt", 32'(dut.r_run_cnt), 32'd0);
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_gnt", 32'(dbg_gnt), 32'd0);

        // ---- 1: CPU-only store then load
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hA5A5_0001;
        #1;
        check("t1_mem_we", 32'(mem_we), 32'd1);
        check("t1_stall", 32'(cpu_stall), 32'd0);
        check("t1_dbg_gnt", 32'(dbg_gnt), 32'd0);
        @(negedge clk);
        cpu_we = 1'b0;
        @(posedge clk); #1;
        check("t1_rdata", cpu_rdata, 32'hA5A5_0001);

        // ---- 2: starvation window, CPU keeps reading 0x10
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t2_c%0d_stall", c), 32'(cpu_stall), 32'd0);
            check($sformatf("t2_c%0d_gnt", c), 32'(dbg_gnt), 32'd0);
            if (c == 0) begin
                check("t2_max0_gnt", 32'(z_dbg_gnt), 32'd1);
                check("t2_max0_stall", 32'(z_cpu_stall), 32'd1);
            end
            @(negedge clk);
        end
        #1;
        check("t2_c4_gnt", 32'(dbg_gnt), 32'd1);
        check("t2_c4_stall", 32'(cpu_stall), 32'd1);
        @(posedge clk); #1;
        check("t2_rvalid", 32'(dbg_rvalid), 32'd1);
        check("t2_rdata", dbg_rdata, 32'hA5A5_0001);
        check("t2_run_cnt", 32'(dut.r_run_cnt), 32'd0);

        // ---- 3: idle CPU, DBG write gets the slot immediately
        @(negedge clk);
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'hDEAD_BEEF;
        #1;
        check("t3_gnt", 32'(dbg_gnt), 32'd1);
        check("t3_mem_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        check("t3_rvalid_wr", 32'(dbg_rvalid), 32'd0);
        @(negedge clk);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        @(posedge clk); #1;
        check("t3_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // ---- 4: locked burst 0x30..0x32
        @(negedge clk);
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 8'h30; dbg_wdata = 32'h3000_0030;
        #1;
        check("t4_gnt0", 32'(dbg_gnt), 32'd1);
        @(posedge clk); #1;
        check("t4_locked", 32'(dut.r_state), 32'(ST_DBG_LOCK));
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        dbg_addr = 8'h31; dbg_wdata = 32'h3100_0031;
        #1;
        check("t4_stall1", 32'(cpu_stall), 32'd1);
        check("t4_gnt1", 32'(dbg_gnt), 32'd1);
        check("t4_addr1", 32'(mem_addr), 32'h31);
        @(negedge clk);
        dbg_addr = 8'h32; dbg_wdata = 32'h3200_0032; dbg_lock = 1'b0;
        #1;
        check("t4_stall2", 32'(cpu_stall), 32'd1);
        check("t4_gnt2", 32'(dbg_gnt), 32'd1);
        check("t4_we2", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        check("t4_unlocked", 32'(dut.r_state), 32'(ST_CPU));
        @(negedge clk);
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        check("t4_cpu_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        check("t4_rd30", cpu_rdata, 32'h3000_0030);
        @(negedge clk);
        cpu_addr = 8'h31;
        @(posedge clk); #1;
        check("t4_rd31", cpu_rdata, 32'h3100_0031);
        @(negedge clk);
        cpu_addr = 8'h32;
        @(posedge clk); #1;
        check("t4_rd32", cpu_rdata, 32'h3200_0032);

        // ---- 5: asynchronous reset in the middle of a locked read burst
        @(negedge clk);
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = 8'h30;
        @(posedge clk); #1;
        check("t5_locked", 32'(dut.r_state), 32'(ST_DBG_LOCK));
        check("t5_rvalid", 32'(dbg_rvalid), 32'd1);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h31;
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_state", 32'(dut.r_state), 32'(ST_CPU));
        check("t5_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("t5_rst_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dbg_req = 1'b0; dbg_lock = 1'b0;
        #1;
        check("t5_post_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        check("t5_post_rdata", cpu_rdata, 32'h3100_0031);

        // ---- 6: simultaneous stores to 0x40, CPU first then DBG
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 32'd1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 32'd2;
        #1;
        check("t6_gnt0", 32'(dbg_gnt), 32'd0);
        check("t6_stall0", 32'(cpu_stall), 32'd0);
        check("t6_wdata0", mem_wdata, 32'd1);
        check("t6_we0", 32'(mem_we), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check("t6_gnt1", 32'(dbg_gnt), 32'd1);
        check("t6_wdata1", mem_wdata, 32'd2);
        @(negedge clk);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_addr = 8'h40;
        @(posedge clk); #1;
        check("t6_rdata", cpu_rdata, 32'd2);
        check("t6_mem40", mem[8'h40], 32'd2);

        @(negedge clk);
        cpu_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
